bus_arbiter: RTL
================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter MaxHold, default 16, meaning maximum consecutive cycles one master may own the shared bus; legal range 2..255.
REQ-002 GlobalClock  input  1  single system clock; all state updates on its rising edge.
REQ-003 Reset_n  input  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
REQ-004 Req  input  4  per-master bus request, bit i = master i, level-sensitive.
REQ-005 Grant  output  4  per-master tri-state enable (drives each master's Data_T), one-hot or all-zero, registered.
REQ-006 Owner  output  2  index of the current grant holder; holds last owner when Grant is zero.
REQ-007 Bus_Idle  output  1  high exactly when Grant is all-zero.
REQ-008 Timeout  output  1  one-cycle pulse when the arbiter forcibly revokes a grant.

Function
REQ-009 The block SHALL implement three states: IDLE, GRANT, TURN (turnaround).
REQ-010 Grant SHALL never have more than one bit set in any cycle, so no two tri-state drivers are enabled together.
REQ-011 IDLE: if Req is nonzero at a rising edge, the block SHALL move to GRANT and set Grant to the round-robin winner at that edge; otherwise stay IDLE.
REQ-012 Arbitration latency SHALL be one edge: Req sampled at edge N produces Grant visible after edge N.
REQ-013 Round-robin winner SHALL be the first requesting master searching from pointer Ptr upward, wrapping 3->0.
REQ-014 On each new grant to master k, Ptr SHALL update to (k+1) mod 4.
REQ-015 GRANT: a 8-bit hold counter SHALL load 1 on grant entry and increment each GRANT cycle.
REQ-016 GRANT SHALL be held while Req[Owner]=1 and hold counter < MaxHold.
REQ-017 If Req[Owner]=0 at an edge, the block SHALL clear Grant and enter TURN at that edge, Timeout stays 0.
REQ-018 If Req[Owner]=1 and hold counter = MaxHold at an edge, the block SHALL clear Grant, enter TURN, and pulse Timeout high for exactly that next cycle.
REQ-019 Simultaneous owner release and hold expiry SHALL count as normal release (no Timeout).
REQ-020 TURN SHALL last exactly one cycle with Grant all-zero; at its end the block SHALL arbitrate as in IDLE (GRANT if any Req, else IDLE).
REQ-021 Minimum gap between two different or identical consecutive grants SHALL be exactly one all-zero cycle.
REQ-022 A master forcibly released SHALL be re-granted only per round-robin order; Ptr already excludes it from highest priority.
REQ-023 Req changes of non-owners during GRANT SHALL have no effect until the next arbitration.
REQ-024 Owner SHALL update in the same edge as Grant on a new grant and otherwise hold.
REQ-025 Bus_Idle SHALL be derived combinationally from the registered Grant.

Reset
REQ-026 While Reset_n=0, regardless of clock: state=IDLE, Grant=0000, Owner=00, Ptr=00, hold counter=0, Timeout=0, Bus_Idle=1.
REQ-027 Reset asserted mid-GRANT SHALL drop Grant to 0000 immediately (asynchronously), with no Timeout pulse.
REQ-028 After Reset_n rises, the first arbitration SHALL occur at the first rising edge with Reset_n=1 and Req nonzero.

Verification
REQ-029 Reset release, Req=0101 held -> Grant=0001 after edge 1, Owner=0, Ptr=1.
REQ-030 Req=1111 constant, each master drops Req after 3 grant cycles then reasserts -> Grant sequence 0001,0000,0010,0000,0100,0000,1000,0000,0001, one idle cycle between each.
REQ-031 MaxHold=4, Req=0010 constant -> Grant=0010 for 4 cycles, then 0000 with Timeout=1 for 1 cycle, then 0010 again; repeat pattern.
REQ-032 MaxHold=4, owner drops Req on the edge its counter reaches 4 -> Grant to 0000, Timeout stays 0.
REQ-033 Reset_n pulsed low mid-grant (Grant=0100) -> Grant=0000, Owner=0, Bus_Idle=1 before next clock edge; after release with Req=1000 -> Grant=1000 after first edge.
REQ-034 Random Req for 10000 cycles -> assertion: Grant one-hot or zero every cycle, Bus_Idle==(Grant==0), no grant longer than MaxHold cycles.

Source files
------------

// File: rtl/bus_arbiter_if.sv
// Bus arbiter request/grant bundle.
//   Req      : per-master level-sensitive bus request (bit i = master i)
//   Grant    : per-master tri-state enable, one-hot or all-zero
//   Owner    : index of the current (or most recent) grant holder
//   Bus_Idle : high exactly when Grant is all-zero
//   Timeout  : one-cycle pulse when a grant is forcibly revoked
// slave modport is the arbiter side, master modport is the requester side.
interface bus_arbiter_if;
    logic [3:0] Req;
    logic [3:0] Grant;
    logic [1:0] Owner;
    logic       Bus_Idle;
    logic       Timeout;

    modport slave  (input Req, output Grant, output Owner, output Bus_Idle, output Timeout);
    modport master (output Req, input Grant, input Owner, input Bus_Idle, input Timeout);
endinterface

// File: rtl/bus_arbiter.sv
// Four-master round-robin bus arbiter with per-grant hold limit.
//   GlobalClock : system clock, rising edge
//   Reset_n     : asynchronous active-low reset
//   bus         : bus_arbiter_if.slave (Req in; Grant, Owner, Bus_Idle, Timeout out)
// Parameter MaxHold (2..255): most consecutive cycles one master may own the bus.
//
// state | meaning
// IDLE  | no grant, arbitrate on any request
// GRANT | one master owns the bus, hold counter running
// TURN  | one all-zero turnaround cycle, then arbitrate as in IDLE
module bus_arbiter #(
    parameter int unsigned MaxHold = 16
) (
    input  logic           GlobalClock,
    input  logic           Reset_n,
    bus_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] grant_q, grant_d;
    logic [1:0] owner_q, owner_d;
    logic [1:0] ptr_q, ptr_d;
    logic [7:0] hold_q, hold_d;
    logic       timeout_q, timeout_d;

    logic [1:0] win;
    logic [1:0] idx;
    logic       found;

    // First requester at or above the pointer, wrapping 3 -> 0.
    always_comb begin
        win   = ptr_q;
        idx   = ptr_q;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = ptr_q + 2'(i);
            if (!found && bus.Req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge GlobalClock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= IDLE;
            grant_q   <= 4'b0000;
            owner_q   <= 2'd0;
            ptr_q     <= 2'd0;
            hold_q    <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE, TURN: begin
                if (found) begin
                    state_d = GRANT;
                    grant_d = 4'b0001 << win;
                    owner_d = win;
                    ptr_d   = win + 2'd1;
                    hold_d  = 8'd1;
                end else begin
                    state_d = IDLE;
                    grant_d = 4'b0000;
                    hold_d  = 8'd0;
                end
            end
            GRANT: begin
                // Release wins over expiry, so a simultaneous drop gives no Timeout.
                if (!bus.Req[owner_q]) begin
                    state_d = TURN;
                    grant_d = 4'b0000;
                    hold_d  = 8'd0;
                end else if (hold_q == 8'(MaxHold)) begin
                    state_d   = TURN;
                    grant_d   = 4'b0000;
                    hold_d    = 8'd0;
                    timeout_d = 1'b1;
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 4'b0000;
                hold_d  = 8'd0;
            end
        endcase
    end

    assign bus.Grant    = grant_q;
    assign bus.Owner    = owner_q;
    assign bus.Timeout  = timeout_q;
    assign bus.Bus_Idle = (grant_q == 4'b0000);

endmodule
